key_scan: RTL and testbench

Debounced key front end feeding the running-light controller. Samples KEY_N raw push-buttons, synchronises and debounces each one independently, and reports a clean level plus single-cycle short-press and long-press events. The light controller consumes these events as its start/stop, direction and speed commands. All timing is in sys_clk cycles (50 MHz board clock).

---
 rtl/key_pkg.sv | 27 ++
 rtl/key_scan_if.sv | 34 +++
 rtl/key_scan_ch.sv | 192 +++++++++++++++++++
 rtl/key_scan.sv | 51 +++++
 tb/tb_key_scan.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/key_pkg.sv
`default_nettype none
// ============================================================================
// Module      : key_pkg
// Description : Shared constants for the debounced key front end: FSM state
//               encodings and default 50 MHz cycle counts.
// Revision    : 1.0 - initial release
// ============================================================================
package key_pkg;

  // Default channel count for the board key header
  localparam int KEY_N_DEFAULT = 4;

  // 20 ms debounce and 1 s long-press at 50 MHz
  localparam int DEB_CYC_50M  = 1_000_000;
  localparam int LONG_CYC_50M = 50_000_000;

  // Per-channel FSM state encodings
  typedef logic [2:0] key_state_t;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_PRESS_DEB = 3'd1;
  localparam logic [2:0] ST_HELD      = 3'd2;
  localparam logic [2:0] ST_LONG_HELD = 3'd3;
  localparam logic [2:0] ST_REL_DEB   = 3'd4;

endpackage
`default_nettype wire

// File: rtl/key_scan_if.sv
`default_nettype none
// ============================================================================
// Module      : key_scan_if
// Description : Bundle of raw key pins and debounced key outputs/events.
//               master drives the raw pins, slave is the key_scan block.
// Revision    : 1.0 - initial release
// ============================================================================
interface key_scan_if
  import key_pkg::*;
#(
  parameter int KEY_N = KEY_N_DEFAULT
);

  logic [KEY_N-1:0] key_in;
  logic [KEY_N-1:0] key_level;
  logic [KEY_N-1:0] key_short;
  logic [KEY_N-1:0] key_long;

  modport master (
    output key_in,
    input  key_level,
    input  key_short,
    input  key_long
  );

  modport slave (
    input  key_in,
    output key_level,
    output key_short,
    output key_long
  );

endinterface
`default_nettype wire

// File: rtl/key_scan_ch.sv
`default_nettype none
// ============================================================================
// Module      : key_scan_ch
// Description : One key channel: 2-FF synchroniser, debounce FSM, and (when
//               KEY_LONG_PRESS_EN is defined) a hold timer for long presses.
//               Input is already polarity-normalised (1 = pressed).
// Revision    : 1.0 - initial release
// ============================================================================
module key_scan_ch
  import key_pkg::*;
#(
  parameter int DEB_CYC  = DEB_CYC_50M
`ifdef KEY_LONG_PRESS_EN
  , parameter int LONG_CYC = LONG_CYC_50M
`endif
) (
  input  wire logic sys_clk,
  input  wire logic sys_rst,
  input  wire logic key_i,
  output logic      key_level_o,
  output logic      key_short_o,
  output logic      key_long_o
);

  localparam int             DEB_W    = $clog2(DEB_CYC);
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYC - 1);

  logic             sync1_q, sync2_q;
  key_state_t       state_q, state_d;
  logic [DEB_W-1:0] deb_q, deb_d;
  logic [DEB_W-1:0] w_deb_inc;
  logic             level_q, level_d;
  logic             short_q, short_d;

`ifdef KEY_LONG_PRESS_EN
  localparam int              HOLD_W    = $clog2(LONG_CYC);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYC - 1);

  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [HOLD_W-1:0] w_hold_inc;
  logic              long_done_q, long_done_d;
  logic              long_q, long_d;

  assign w_hold_inc = hold_q + 1'b1;
`endif

  // The terminal compare looks at the incremented value so the sample that
  // entered PRESS_DEB/REL_DEB counts as the first of DEB_CYC stable samples.
  assign w_deb_inc = deb_q + 1'b1;

  // Two-stage synchroniser; reset leaves it at the released level
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= key_i;
      sync2_q <= sync1_q;
    end
  end

  // Next-state logic for debounce and hold timing
  always_comb begin
    state_d = state_q;
    deb_d   = deb_q;
    level_d = level_q;
    short_d = 1'b0;
`ifdef KEY_LONG_PRESS_EN
    hold_d      = hold_q;
    long_done_d = long_done_q;
    long_d      = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (sync2_q) begin
          state_d = ST_PRESS_DEB;
          deb_d   = '0;
        end
      end
      ST_PRESS_DEB: begin
        if (!sync2_q) begin
          state_d = ST_IDLE;
        end else if (w_deb_inc == DEB_LAST) begin
          state_d = ST_HELD;
          level_d = 1'b1;
`ifdef KEY_LONG_PRESS_EN
          hold_d      = '0;
          long_done_d = 1'b0;
`endif
        end else begin
          deb_d = w_deb_inc;
        end
      end
      ST_HELD: begin
`ifdef KEY_LONG_PRESS_EN
        // Long event wins over a same-cycle release; LONG_HELD handles it next
        if (hold_q == HOLD_LAST) begin
          long_d      = 1'b1;
          long_done_d = 1'b1;
          state_d     = ST_LONG_HELD;
        end else begin
          hold_d = w_hold_inc;
          if (!sync2_q) begin
            state_d = ST_REL_DEB;
            deb_d   = '0;
          end
        end
`else
        if (!sync2_q) begin
          state_d = ST_REL_DEB;
          deb_d   = '0;
        end
`endif
      end
`ifdef KEY_LONG_PRESS_EN
      ST_LONG_HELD: begin
        if (!sync2_q) begin
          state_d = ST_REL_DEB;
          deb_d   = '0;
        end
      end
`endif
      ST_REL_DEB: begin
`ifdef KEY_LONG_PRESS_EN
        // Keep timing through a release glitch; saturate so a long event
        // reached here fires on the return to HELD.
        if (!long_done_q && (hold_q != HOLD_LAST)) begin
          hold_d = w_hold_inc;
        end
        if (sync2_q) begin
          state_d = long_done_q ? ST_LONG_HELD : ST_HELD;
        end else if (w_deb_inc == DEB_LAST) begin
          state_d = ST_IDLE;
          level_d = 1'b0;
          short_d = !long_done_q;
        end else begin
          deb_d = w_deb_inc;
        end
`else
        if (sync2_q) begin
          state_d = ST_HELD;
        end else if (w_deb_inc == DEB_LAST) begin
          state_d = ST_IDLE;
          level_d = 1'b0;
          short_d = 1'b1;
        end else begin
          deb_d = w_deb_inc;
        end
`endif
      end
      default: begin
        state_d = ST_IDLE;
        level_d = 1'b0;
      end
    endcase
  end

  // State, counters and registered outputs
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q <= ST_IDLE;
      deb_q   <= '0;
      level_q <= 1'b0;
      short_q <= 1'b0;
`ifdef KEY_LONG_PRESS_EN
      hold_q      <= '0;
      long_done_q <= 1'b0;
      long_q      <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      deb_q   <= deb_d;
      level_q <= level_d;
      short_q <= short_d;
`ifdef KEY_LONG_PRESS_EN
      hold_q      <= hold_d;
      long_done_q <= long_done_d;
      long_q      <= long_d;
`endif
    end
  end

  assign key_level_o = level_q;
  assign key_short_o = short_q;
`ifdef KEY_LONG_PRESS_EN
  assign key_long_o  = long_q;
`else
  assign key_long_o  = 1'b0;
`endif

endmodule
`default_nettype wire

// File: rtl/key_scan.sv
`default_nettype none
// ============================================================================
// Module      : key_scan
// Description : Debounced key front end. Normalises key polarity and
//               instantiates one key_scan_ch per key. Long-press detection is
//               built only when KEY_LONG_PRESS_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module key_scan
  import key_pkg::*;
#(
  parameter int KEY_N          = KEY_N_DEFAULT,
  parameter int DEB_CYC        = DEB_CYC_50M,
  parameter int LONG_CYC       = LONG_CYC_50M,
  parameter int KEY_ACTIVE_LOW = 1
) (
  input  wire logic  sys_clk,
  input  wire logic  sys_rst,
  key_scan_if.slave  keys
);

  logic [KEY_N-1:0] w_key_norm;
  logic [KEY_N-1:0] w_level;
  logic [KEY_N-1:0] w_short;
  logic [KEY_N-1:0] w_long;

  // Present every channel with press = 1
  assign w_key_norm = (KEY_ACTIVE_LOW != 0) ? ~keys.key_in : keys.key_in;

  for (genvar g = 0; g < KEY_N; g++) begin : g_ch
    key_scan_ch #(
      .DEB_CYC  (DEB_CYC)
`ifdef KEY_LONG_PRESS_EN
      , .LONG_CYC (LONG_CYC)
`endif
    ) u_ch (
      .sys_clk     (sys_clk),
      .sys_rst     (sys_rst),
      .key_i       (w_key_norm[g]),
      .key_level_o (w_level[g]),
      .key_short_o (w_short[g]),
      .key_long_o  (w_long[g])
    );
  end

  assign keys.key_level = w_level;
  assign keys.key_short = w_short;
  assign keys.key_long  = w_long;

endmodule
`default_nettype wire

// File: tb/tb_key_scan.sv
`default_nettype none
// ============================================================================
// Module      : tb_key_scan
// Description : Directed self-checking bench for key_scan with DEB_CYC=4,
//               LONG_CYC=16, active-low keys. Long-press expectations follow
//               KEY_LONG_PRESS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_key_scan;

`ifdef KEY_LONG_PRESS_EN
  localparam bit LONG_EN = 1'b1;
`else
  localparam bit LONG_EN = 1'b0;
`endif

  logic sys_clk = 1'b0;
  logic sys_rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;

  key_scan_if #(.KEY_N(4)) bus ();

  key_scan #(
    .KEY_N          (4),
    .DEB_CYC        (4),
    .LONG_CYC       (16),
    .KEY_ACTIVE_LOW (1)
  ) dut (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .keys    (bus)
  );

  always #5 sys_clk = ~sys_clk;

  // Drive pins for one cycle, then observe 1 time unit after the edge
  task automatic step(input logic [3:0] pins);
    bus.key_in = pins;
    @(posedge sys_clk);
    #1;
    cyc++;
  endtask

  task automatic test_reset();
    sys_rst = 1'b1;
    repeat (3) step(4'b1111);
    checks++;
    if ({bus.key_level, bus.key_short, bus.key_long} !== 12'h000) begin
      failures++;
      $display("FAIL reset_outputs: got %h expected 000", {bus.key_level, bus.key_short, bus.key_long});
    end
    sys_rst = 1'b0;
    repeat (6) step(4'b1111);
    checks++;
    if ({bus.key_level, bus.key_short, bus.key_long} !== 12'h000) begin
      failures++;
      $display("FAIL idle_outputs: got %h expected 000", {bus.key_level, bus.key_short, bus.key_long});
    end
  endtask

  task automatic test_clean_press();
    int t0, rise, fall, short_at, nshort, nlong;
    rise = -1; fall = -1; short_at = -1; nshort = 0; nlong = 0;
    t0 = cyc;
    repeat (12) begin
      step(4'b1110);
      if (rise < 0 && bus.key_level[0]) rise = cyc - t0;
      nshort += $countones(bus.key_short);
      nlong  += $countones(bus.key_long);
    end
    checks++;
    if (rise !== 6) begin failures++; $display("FAIL clean_rise: got %0d expected 6", rise); end
    t0 = cyc;
    repeat (12) begin
      step(4'b1111);
      if (fall < 0 && !bus.key_level[0]) fall = cyc - t0;
      if (short_at < 0 && bus.key_short[0]) short_at = cyc - t0;
      nshort += $countones(bus.key_short);
      nlong  += $countones(bus.key_long);
    end
    checks++;
    if (fall !== 6) begin failures++; $display("FAIL clean_fall: got %0d expected 6", fall); end
    checks++;
    if (short_at !== 6) begin failures++; $display("FAIL clean_short_at: got %0d expected 6", short_at); end
    checks++;
    if (nshort !== 1) begin failures++; $display("FAIL clean_short_count: got %0d expected 1", nshort); end
    checks++;
    if (nlong !== 0) begin failures++; $display("FAIL clean_long_count: got %0d expected 0", nlong); end
  endtask

  task automatic test_bounce();
    // Pin per cycle (0 = pressed): low3 high1 low2 high1 low10
    logic [16:0] pat;
    int t0, rise, npulse, nshort;
    pat = 17'b0000000000_1_00_1_000;
    rise = -1; npulse = 0; nshort = 0;
    t0 = cyc;
    for (int i = 0; i < 17; i++) begin
      step({3'b111, pat[i]});
      if (rise < 0 && bus.key_level[0]) rise = cyc - t0;
      npulse += $countones(bus.key_short) + $countones(bus.key_long);
    end
    checks++;
    if (rise !== 13) begin failures++; $display("FAIL bounce_rise: got %0d expected 13", rise); end
    checks++;
    if (npulse !== 0) begin failures++; $display("FAIL bounce_pulses: got %0d expected 0", npulse); end
    repeat (12) begin
      step(4'b1111);
      nshort += $countones(bus.key_short);
    end
    checks++;
    if (nshort !== 1) begin failures++; $display("FAIL bounce_release_short: got %0d expected 1", nshort); end
  endtask

  task automatic test_long_hold();
    int t0, rise, long_at, fall, nlong, nshort;
    rise = -1; long_at = -1; fall = -1; nlong = 0; nshort = 0;
    t0 = cyc;
    repeat (40) begin
      step(4'b1101);
      if (rise < 0 && bus.key_level[1]) rise = cyc - t0;
      if (long_at < 0 && bus.key_long[1]) long_at = cyc - t0;
      nlong  += $countones(bus.key_long);
      nshort += $countones(bus.key_short);
    end
    checks++;
    if (rise !== 6) begin failures++; $display("FAIL long_rise: got %0d expected 6", rise); end
    checks++;
    if (long_at !== (LONG_EN ? 22 : -1)) begin
      failures++; $display("FAIL long_at: got %0d expected %0d", long_at, LONG_EN ? 22 : -1);
    end
    t0 = cyc;
    repeat (12) begin
      step(4'b1111);
      if (fall < 0 && !bus.key_level[1]) fall = cyc - t0;
      nlong  += $countones(bus.key_long);
      nshort += $countones(bus.key_short);
    end
    checks++;
    if (fall !== 6) begin failures++; $display("FAIL long_fall: got %0d expected 6", fall); end
    checks++;
    if (nlong !== (LONG_EN ? 1 : 0)) begin
      failures++; $display("FAIL long_count: got %0d expected %0d", nlong, LONG_EN ? 1 : 0);
    end
    checks++;
    if (nshort !== (LONG_EN ? 0 : 1)) begin
      failures++; $display("FAIL long_short_count: got %0d expected %0d", nshort, LONG_EN ? 0 : 1);
    end
  endtask

  task automatic test_release_glitch();
    int t0, rise, long_at, drops, nshort_hold, nshort_rel, fall;
    rise = -1; long_at = -1; drops = 0; nshort_hold = 0; nshort_rel = 0; fall = -1;
    t0 = cyc;
    for (int i = 0; i < 40; i++) begin
      step((i == 10 || i == 11) ? 4'b1111 : 4'b1011);
      if (rise < 0 && bus.key_level[2]) rise = cyc - t0;
      if (rise >= 0 && !bus.key_level[2]) drops++;
      if (long_at < 0 && bus.key_long[2]) long_at = cyc - t0;
      nshort_hold += $countones(bus.key_short);
    end
    checks++;
    if (rise !== 6) begin failures++; $display("FAIL glitch_rise: got %0d expected 6", rise); end
    checks++;
    if (drops !== 0) begin failures++; $display("FAIL glitch_level_drops: got %0d expected 0", drops); end
    checks++;
    if (nshort_hold !== 0) begin failures++; $display("FAIL glitch_short: got %0d expected 0", nshort_hold); end
    checks++;
    if (long_at !== (LONG_EN ? 22 : -1)) begin
      failures++; $display("FAIL glitch_long_at: got %0d expected %0d", long_at, LONG_EN ? 22 : -1);
    end
    t0 = cyc;
    repeat (12) begin
      step(4'b1111);
      if (fall < 0 && !bus.key_level[2]) fall = cyc - t0;
      nshort_rel += $countones(bus.key_short);
    end
    checks++;
    if (fall !== 6) begin failures++; $display("FAIL glitch_fall: got %0d expected 6", fall); end
    checks++;
    if (nshort_rel !== (LONG_EN ? 0 : 1)) begin
      failures++; $display("FAIL glitch_release_short: got %0d expected %0d", nshort_rel, LONG_EN ? 0 : 1);
    end
  endtask

  task automatic test_simultaneous();
    int t0, rise, short_at, nmis, nother, nshort3;
    rise = -1; short_at = -1; nmis = 0; nother = 0; nshort3 = 0;
    t0 = cyc;
    for (int i = 0; i < 24; i++) begin
      step((i < 12) ? 4'b0110 : 4'b1111);
      if (rise < 0 && bus.key_level[3]) rise = cyc - t0;
      if (short_at < 0 && bus.key_short[3]) short_at = cyc - t0;
      if ({bus.key_level[0], bus.key_short[0], bus.key_long[0]} !==
          {bus.key_level[3], bus.key_short[3], bus.key_long[3]}) nmis++;
      if ({bus.key_level[2:1], bus.key_short[2:1], bus.key_long[2:1]} !== 6'b0) nother++;
      nshort3 += int'(bus.key_short[3]);
    end
    checks++;
    if (rise !== 6) begin failures++; $display("FAIL simul_rise: got %0d expected 6", rise); end
    checks++;
    if (short_at !== 18) begin failures++; $display("FAIL simul_short_at: got %0d expected 18", short_at); end
    checks++;
    if (nmis !== 0) begin failures++; $display("FAIL simul_coincidence: got %0d differing cycles expected 0", nmis); end
    checks++;
    if (nother !== 0) begin failures++; $display("FAIL simul_idle_channels: got %0d active cycles expected 0", nother); end
    checks++;
    if (nshort3 !== 1) begin failures++; $display("FAIL simul_short_count: got %0d expected 1", nshort3); end
  endtask

  task automatic test_reset_mid_press();
    int t0, rise, nshort_pre, nshort_rel;
    rise = -1; nshort_pre = 0; nshort_rel = 0;
    repeat (10) step(4'b1110);
    checks++;
    if (bus.key_level[0] !== 1'b1) begin
      failures++; $display("FAIL rst_pre_level: got %b expected 1", bus.key_level[0]);
    end
    sys_rst = 1'b1;
    step(4'b1110);
    sys_rst = 1'b0;
    t0 = cyc;
    checks++;
    if ({bus.key_level, bus.key_short, bus.key_long} !== 12'h000) begin
      failures++; $display("FAIL rst_mid_outputs: got %h expected 000", {bus.key_level, bus.key_short, bus.key_long});
    end
    repeat (8) begin
      step(4'b1110);
      if (rise < 0 && bus.key_level[0]) rise = cyc - t0;
      nshort_pre += $countones(bus.key_short) + $countones(bus.key_long);
    end
    checks++;
    if (rise !== 6) begin failures++; $display("FAIL rst_rerise: got %0d expected 6", rise); end
    checks++;
    if (nshort_pre !== 0) begin failures++; $display("FAIL rst_aborted_pulse: got %0d expected 0", nshort_pre); end
    repeat (12) begin
      step(4'b1111);
      nshort_rel += $countones(bus.key_short);
    end
    checks++;
    if (nshort_rel !== 1) begin failures++; $display("FAIL rst_fresh_short: got %0d expected 1", nshort_rel); end
  endtask

  initial begin
    bus.key_in = 4'b1111;
    test_reset();
    test_clean_press();
    test_bounce();
    test_long_hold();
    test_release_glitch();
    test_simultaneous();
    test_reset_mid_press();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
